// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one synchronous single-port RAM with lock bursts and a burst limit.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic        lock0,
  input  logic [9:0]  addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        valid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic        lock1,
  input  logic [9:0]  addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        valid1,
  output logic [31:0] rdata1,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic             prio_ptr, prio_ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             burst_hit;
  logic             vld0_p1, vld1_p1, rd0_p1, rd1_p1;
  logic [31:0]      rdata0_p1, rdata1_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= BURST_MAX) return BURST_MAX;
    return v + 1'b1;
  endfunction

  assign burst_hit = (burst_cnt == BURST_MAX);

  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_nxt     = IDLE;
    prio_ptr_nxt  = prio_ptr;
    burst_cnt_nxt = '0;
    // An owner keeps the port unless the burst limit is hit while the other side waits
    if (state == OWN0 && req0) begin
      if (burst_hit && req1) gnt1 = 1'b1;
      else                   gnt0 = 1'b1;
    end else if (state == OWN1 && req1) begin
      if (burst_hit && req0) gnt0 = 1'b1;
      else                   gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = ~prio_ptr;
      gnt1 = prio_ptr;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      state_nxt     = lock0 ? OWN0 : IDLE;
      burst_cnt_nxt = (state == OWN0) ? sat_inc(burst_cnt) : CNT_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
      if (!lock0) prio_ptr_nxt = 1'b1;
`endif
    end else if (gnt1) begin
      state_nxt     = lock1 ? OWN1 : IDLE;
      burst_cnt_nxt = (state == OWN1) ? sat_inc(burst_cnt) : CNT_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
      if (!lock1) prio_ptr_nxt = 1'b0;
`endif
    end
  end

  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : 10'd0);
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : 32'd0);

  // Stage p1: access completes, RAM read data is on mem_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio_ptr  <= 1'b0;
      burst_cnt <= '0;
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
      rd0_p1    <= 1'b0;
      rd1_p1    <= 1'b0;
      rdata0_p1 <= 32'd0;
      rdata1_p1 <= 32'd0;
    end else begin
      state     <= state_nxt;
      prio_ptr  <= prio_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      vld0_p1   <= gnt0;
      vld1_p1   <= gnt1;
      rd0_p1    <= gnt0 & ~we0;
      rd1_p1    <= gnt1 & ~we1;
      if (vld0_p1 && rd0_p1) rdata0_p1 <= mem_rdata;
      if (vld1_p1 && rd1_p1) rdata1_p1 <= mem_rdata;
    end
  end

  assign valid0 = vld0_p1;
  assign valid1 = vld1_p1;
  assign rdata0 = (vld0_p1 && rd0_p1) ? mem_rdata : rdata0_p1;
  assign rdata1 = (vld1_p1 && rd1_p1) ? mem_rdata : rdata1_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus multi-cycle arbitration sequences.
module tb_mem_port_arbiter;
  localparam bit RR =
`ifdef ARB_ROUND_ROBIN_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk, rst;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, valid0, valid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .valid0(valid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .valid1(valid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic r0, w0, l0; logic [9:0] a0; logic [31:0] d0;
    logic r1, w1, l1; logic [9:0] a1; logic [31:0] d1;
    logic eg0, eg1, ev0, ev1, een, ewe;
    logic [9:0] eaddr; logic [31:0] ewd, erd0, erd1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    ram[5] = 32'hDEADBEEF;
    ram[0] = 32'h11111111;
    ram[1] = 32'h22222222;
    mem_rdata = 32'd0;
    idle_inputs();
    rst = 1'b1;

    //           r0 w0 l0 a0      d0             r1 w1 l1 a1      d1             g0 g1 v0 v1 en we addr    wdata          rd0            rd1
    vecs[0]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 0, 10'h000, 32'h0,        32'h0,         32'h0};
    vecs[1]  = '{1, 0, 0, 10'h005, 32'h0,        0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 0, 1, 0, 10'h005, 32'h0,        32'h0,         32'h0};
    vecs[2]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 1, 0, 0, 0, 10'h000, 32'h0,        32'hDEADBEEF,  32'h0};
    vecs[3]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 0, 10'h000, 32'h0,        32'hDEADBEEF,  32'h0};
    vecs[4]  = '{0, 0, 0, 10'h000, 32'h0,        1, 1, 0, 10'h3FF, 32'h12345678, 0, 1, 0, 0, 1, 1, 10'h3FF, 32'h12345678, 32'hDEADBEEF,  32'h0};
    vecs[5]  = '{1, 0, 0, 10'h3FF, 32'h0,        0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 1, 1, 0, 10'h3FF, 32'h0,        32'hDEADBEEF,  32'h0};
    vecs[6]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 1, 0, 0, 0, 10'h000, 32'h0,        32'h12345678,  32'h0};
    vecs[7]  = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 0, 10'h000, 32'h0,        32'h12345678,  32'h0};
    vecs[8]  = '{1, 1, 0, 10'h00A, 32'hCAFEF00D, 0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 0, 1, 1, 10'h00A, 32'hCAFEF00D, 32'h12345678,  32'h0};
    vecs[9]  = '{0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 10'h00A, 32'h0,        0, 1, 1, 0, 1, 0, 10'h00A, 32'h0,        32'h12345678,  32'h0};
    vecs[10] = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 1, 0, 0, 10'h000, 32'h0,        32'h12345678,  32'hCAFEF00D};
    vecs[11] = '{0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 0, 10'h000, 32'h0,        32'h12345678,  32'hCAFEF00D};
    vecs[12] = '{0, 1, 1, 10'h3FF, 32'hFFFFFFFF, 0, 1, 1, 10'h155, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 0, 10'h000, 32'h0,        32'h12345678,  32'hCAFEF00D};

    // Reset state while rst is held
    @(negedge clk);
    #2;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_valid0", {31'd0, valid0}, 32'd0);
    chk("rst_valid1", {31'd0, valid1}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: single read, write/read-back both ways, don't-care inputs
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req0 = vecs[i].r0; we0 = vecs[i].w0; lock0 = vecs[i].l0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; lock1 = vecs[i].l1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      #2;
      chk($sformatf("v%0d_gnt0", i), {31'd0, gnt0}, {31'd0, vecs[i].eg0});
      chk($sformatf("v%0d_gnt1", i), {31'd0, gnt1}, {31'd0, vecs[i].eg1});
      chk($sformatf("v%0d_valid0", i), {31'd0, valid0}, {31'd0, vecs[i].ev0});
      chk($sformatf("v%0d_valid1", i), {31'd0, valid1}, {31'd0, vecs[i].ev1});
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].een});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].ewe});
      chk($sformatf("v%0d_mem_addr", i), {22'd0, mem_addr}, {22'd0, vecs[i].eaddr});
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].ewd);
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].erd0);
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].erd1);
    end

    // Contention from reset, no lock
    do_reset();
    req0 = 1; addr0 = 10'h000; req1 = 1; addr1 = 10'h001;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("cont%0d_gnt0", i), {31'd0, gnt0}, RR ? {31'd0, ~i[0]} : 32'd1);
      chk($sformatf("cont%0d_gnt1", i), {31'd0, gnt1}, RR ? {31'd0, i[0]} : 32'd0);
      @(negedge clk);
    end

    // Burst limit: locked requester 0 vs waiting requester 1
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 10'h005; req1 = 1; addr1 = 10'h001;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("burst%0d_gnt0", i), {31'd0, gnt0}, (i == 8) ? 32'd0 : 32'd1);
      chk($sformatf("burst%0d_gnt1", i), {31'd0, gnt1}, (i == 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Withdraw: one-cycle req1 pulse during a short locked burst
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 10'h000;
    for (int i = 0; i < 5; i++) begin
      req1 = (i == 2);
      addr1 = 10'h001;
      #2;
      chk($sformatf("wd%0d_gnt0", i), {31'd0, gnt0}, 32'd1);
      chk($sformatf("wd%0d_gnt1", i), {31'd0, gnt1}, 32'd0);
      chk($sformatf("wd%0d_valid1", i), {31'd0, valid1}, 32'd0);
      @(negedge clk);
    end
    idle_inputs();
    #2;
    chk("wd_tail_valid0", {31'd0, valid0}, 32'd1);
    chk("wd_tail_valid1", {31'd0, valid1}, 32'd0);
    @(negedge clk);
    #2;
    chk("wd_end_valid0", {31'd0, valid0}, 32'd0);

    // Asynchronous reset in the middle of a locked burst
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 10'h005;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("mid_rst_valid0", {31'd0, valid0}, 32'd0);
    chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("mid_rst_rdata0", rdata0, 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_valid0", {31'd0, valid0}, 32'd0);
    @(negedge clk);
    #2;
    chk("post_rst_valid0_b", {31'd0, valid0}, 32'd0);
    @(negedge clk);
    req0 = 1; req1 = 1; addr1 = 10'h001;
    #2;
    chk("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
    chk("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
    @(negedge clk);
    #2;
    chk("post_rst2_gnt0", {31'd0, gnt0}, RR ? 32'd0 : 32'd1);
    chk("post_rst2_gnt1", {31'd0, gnt1}, RR ? 32'd1 : 32'd0);
    @(negedge clk);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
